// File: rtl/aq_gemac_rx_reader.sv
// aq_gemac_rx_reader
//   Drains complete frames from the aq_gemac RX buffer and re-emits the payload
//   as a valid/ready 32-bit stream with last/keep framing. The header word of
//   each frame is read and discarded. Frames of length 0 or longer than MAX_LEN
//   are dropped and flagged on err_pulse.
//
// Optional feature macro: AQ_GEMAC_RX_DROP_ERR_EN
//   Defined   : frames whose latched status[1:0] != 0 are read out of the buffer
//               but not forwarded; err_pulse fires when the frame is finished.
//   Undefined : such frames are forwarded normally, with frame_status carrying
//               the error bits.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   rx_buff_valid     a complete frame is waiting in the RX buffer
//   rx_buff_length    frame byte length
//   rx_buff_status    frame status (bit0 CRC error, bit1 length error)
//   rx_buff_re        read enable, one word per cycle
//   rx_buff_data      read data, RD_LATENCY cycles after rx_buff_re
//   m_valid/m_ready   output handshake
//   m_data            payload, byte n in bits [8n+7:8n]
//   m_keep            byte enables, 4'hF except on the last word
//   m_last            last word of the frame
//   frame_status      status latched at frame start
//   frame_len         length latched at frame start
//   err_pulse         one-cycle pulse when a frame is dropped
//
// state | meaning
// IDLE  | waiting for rx_buff_valid
// HDR   | one-cycle header read, word discarded on return
// BODY  | payload reads, gated by FIFO credit
// FLUSH | waiting for reads still in flight to land

module aq_gemac_rx_reader #(
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_LEN    = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_buff_valid,
    input  logic [15:0] rx_buff_length,
    input  logic [15:0] rx_buff_status,
    output logic        rx_buff_re,
    input  logic [31:0] rx_buff_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [3:0]  m_keep,
    output logic        m_last,
    output logic [15:0] frame_status,
    output logic [15:0] frame_len,
    output logic        err_pulse
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, HDR, BODY, FLUSH} state_t;

    state_t state, state_nx;

    logic [11:0]           wc;
    logic [11:0]           rd_cnt;
    logic                  len_bad;
    logic                  drop;
    logic                  err_nx;
    logic                  issue_push;
    logic                  issue_last;
    logic                  credit_ok;
    logic [2:0]            inflight;
    logic [CW:0]           free_cnt;
    logic [3:0]            keep_last;

    // Read-return pipeline: valid, "push to FIFO" and "last payload word" tags.
    logic [RD_LATENCY-1:0] pv;
    logic [RD_LATENCY-1:0] pp;
    logic [RD_LATENCY-1:0] pl;

    logic [31:0]           mem_data [FIFO_DEPTH];
    logic [3:0]            mem_keep [FIFO_DEPTH];
    logic                  mem_last [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  push;
    logic                  pop;

`ifdef AQ_GEMAC_RX_DROP_ERR_EN
    assign drop = |frame_status[1:0];
`else
    assign drop = 1'b0;
`endif

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + {2'b00, pv[i]};
        end
    end

    // Header reads are counted as in-flight too, which keeps the rule simple
    // and only costs a credit for one cycle at frame start.
    assign free_cnt  = (CW+1)'(FIFO_DEPTH) - {1'b0, count};
    assign credit_ok = free_cnt > (CW+1)'(inflight);

    always_comb begin
        case (frame_len[1:0])
            2'd1:    keep_last = 4'h1;
            2'd2:    keep_last = 4'h3;
            2'd3:    keep_last = 4'h7;
            default: keep_last = 4'hF;
        endcase
    end

    always_comb begin
        state_nx   = state;
        rx_buff_re = 1'b0;
        issue_push = 1'b0;
        issue_last = 1'b0;
        err_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (rx_buff_valid) state_nx = HDR;
            end
            HDR: begin
                rx_buff_re = 1'b1;
                if (len_bad) begin
                    err_nx   = 1'b1;
                    state_nx = FLUSH;
                end else begin
                    state_nx = BODY;
                end
            end
            BODY: begin
                if (credit_ok) begin
                    rx_buff_re = 1'b1;
                    issue_push = !drop;
                    issue_last = (rd_cnt == wc - 12'd1);
                    if (rd_cnt == wc - 12'd1) state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (inflight == 3'd0) begin
                    err_nx   = drop && !len_bad;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            frame_len    <= '0;
            frame_status <= '0;
            wc           <= '0;
            len_bad      <= 1'b0;
            rd_cnt       <= '0;
            err_pulse    <= 1'b0;
            pv           <= '0;
            pp           <= '0;
            pl           <= '0;
        end else begin
            state     <= state_nx;
            err_pulse <= err_nx;
            if (state == IDLE && rx_buff_valid) begin
                frame_len    <= rx_buff_length;
                frame_status <= rx_buff_status;
                wc           <= rx_buff_length[13:2] + {11'd0, |rx_buff_length[1:0]};
                len_bad      <= (rx_buff_length == 16'd0) ||
                                (rx_buff_length > 16'(MAX_LEN));
                rd_cnt       <= '0;
            end else if (state == BODY && rx_buff_re) begin
                rd_cnt <= rd_cnt + 12'd1;
            end
            pv[0] <= rx_buff_re;
            pp[0] <= issue_push;
            pl[0] <= issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pp[i] <= pp[i-1];
                pl[i] <= pl[i-1];
            end
        end
    end

    assign push = pv[RD_LATENCY-1] && pp[RD_LATENCY-1];
    assign pop  = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= rx_buff_data;
            mem_keep[wr_ptr] <= pl[RD_LATENCY-1] ? keep_last : 4'hF;
            mem_last[wr_ptr] <= pl[RD_LATENCY-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Outputs are gated so they read as zero whenever the FIFO is empty.
    assign m_valid = (count != '0);
    assign m_data  = m_valid ? mem_data[rd_ptr] : 32'd0;
    assign m_keep  = m_valid ? mem_keep[rd_ptr] : 4'd0;
    assign m_last  = m_valid ? mem_last[rd_ptr] : 1'b0;

endmodule
